vc_alloc_ctrl: RTL and testbench
================================

// Module: vc_alloc_ctrl
// PURPOSE
//  Output-VC allocation controller for the VC router. Holds registered per-output-port VC availability,
//  round-robin arbitrates input-VC requests per output port, assigns one free downstream VC per winner,
//  and returns VCs when the downstream router releases them. Sits between route compute and switch alloc.
// PARAMETERS
//  NUM_PORTS  5  router ports (input and output)
//  NUM_VCS    4  VCs per port
//  PORT_W     localparam $clog2(NUM_PORTS); VC_W localparam $clog2(NUM_VCS)
//  Requester index r = in_port*NUM_VCS+in_vc; VC slot index s = out_port*NUM_VCS+out_vc
// PORTS
//  clk              in   1                      clock, all state on posedge
//  reset            in   1                      asynchronous, active-high
//  req              in   NUM_PORTS*NUM_VCS      bit r: input VC r requests an output VC
//  req_outport      in   NUM_PORTS*NUM_VCS*PORT_W  field r: requested output port
//  vc_release       in   NUM_PORTS*NUM_VCS      bit s: downstream frees output VC s (1-cycle pulse)
//  grant            out  NUM_PORTS*NUM_VCS      bit r: registered 1-cycle grant pulse
//  grant_vc         out  NUM_PORTS*NUM_VCS*VC_W field r: assigned out_vc, valid while grant[r]
//  vc_availability  out  NUM_PORTS*NUM_VCS      bit s: 1 = output VC s free (registered)
//  err_release      out  1                      only when VCA_ERR_CHECK_EN defined; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async): vc_availability all 1s, grant 0, grant_vc 0, all RR pointers 0, err_release 0.
//  - Cycle T: arbitration uses registered vc_availability and req masked by grant (req[r] ignored while
//    grant[r]=1). grant/grant_vc/vc_availability update at edge T+1: latency req->grant = 1 cycle.
//  - Handshake: requester holds req[r] and req_outport[r] stable until grant[r] seen; drops req the
//    cycle after. Dropping req before grant withdraws the request; no state is kept for it.
//  - Per output port p: eligible set = {r : req[r], !grant[r], req_outport[r]==p}. If eligible non-empty
//    and port p has >=1 free VC: winner = first eligible r at or after rr_ptr[p] (wrapping past
//    NUM_PORTS*NUM_VCS-1 to 0); assigned VC = highest-index free out_vc of port p.
//  - Max one grant per output port per cycle; one requester targets one port, so no requester double-granted.
//  - On grant: clear availability bit of assigned slot; rr_ptr[p] <= winner+1 (wraps to 0). No grant -> ptr holds.
//  - Port p with zero free VCs: no grant, ptr holds, requests wait (no starvation once a VC frees: RR fairness).
//  - req_outport[r] >= NUM_PORTS: request never granted, no other effect.
//  - vc_release[s]: sets availability bit s at next edge; released VC visible to arbitration one cycle later.
//  - Release and allocation of same slot same cycle impossible (alloc only from free slots); release of a
//    different slot in same port as an allocation: both applied at the same edge.
//  - Release of an already-free slot: bit stays 1 (no overflow); flagged only with VCA_ERR_CHECK_EN.
//  - Reset asserted mid-operation: in-flight grants dropped, all VCs free; requesters re-request.
// CONFIGURATION
//  VCA_ERR_CHECK_EN defined: err_release port present; set sticky (until reset) on the edge after any
//   vc_release[s]=1 while vc_availability[s]=1. Undefined: port absent, no check logic; release of free slot
//   silently ignored.
// TESTING
//  1 Reset -> vc_availability=20'hFFFFF, grant=0; reset asserted mid-run clears grants within same cycle.
//  2 req[0]=1 outport=2 at T -> grant[0]=1 at T+1, grant_vc[0]=3, vc_availability[11]=0; req held at T+1 -> no regrant.
//  3 req[0],req[4],req[8] all outport=1, all VCs free -> grants r=0,4,8 on consecutive cycles, vc 3,2,1.
//  4 Port 3 exhausted (4 grants), 5th requester waits; vc_release[13] pulse at T -> grant_vc=1 at T+2.
//  5 RR fairness: r=1 and r=5 hold req to port 0, each grant followed by release -> grants alternate 1,5,1,5.
//  6 VCA_ERR_CHECK_EN: vc_release[0]=1 after reset -> err_release=1 next edge, sticky; without macro no port.

Source files
------------

// File: rtl/vc_alloc_ctrl.sv
// Output-VC allocation controller for the VC router.
// Tracks per-output-port VC availability, round-robin arbitrates input-VC requests per output
// port, hands each winner the highest-index free VC of that port, and returns VCs when the
// downstream router releases them.
// Optional feature: define VCA_ERR_CHECK_EN to add the sticky err_release output, which flags a
// release of an output VC that was already free.
module vc_alloc_ctrl #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned NUM_VCS   = 4,
  localparam int unsigned PORT_W   = $clog2(NUM_PORTS),
  localparam int unsigned VC_W     = $clog2(NUM_VCS),
  localparam int unsigned NR       = NUM_PORTS * NUM_VCS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NR-1:0]        req,
  input  logic [NR*PORT_W-1:0] req_outport,
  input  logic [NR-1:0]        vc_release,
  output logic [NR-1:0]        grant,
  output logic [NR*VC_W-1:0]   grant_vc,
  output logic [NR-1:0]        vc_availability
`ifdef VCA_ERR_CHECK_EN
  ,
  output logic                 err_release
`endif
);

  localparam int unsigned RW = $clog2(NR);

  logic [NR-1:0]      avail_q, avail_d;
  logic [NR-1:0]      grant_q, grant_d;
  logic [NR*VC_W-1:0] grant_vc_q, grant_vc_d;
  logic [RW-1:0]      rr_ptr_q [NUM_PORTS];
  logic [RW-1:0]      rr_ptr_d [NUM_PORTS];
  logic [NR-1:0]      alloc;
  logic [NR-1:0]      elig_req;

  // Per output port: pick the RR winner and the highest free VC, then build next state.
  always_comb begin
    int unsigned  idx;
    int unsigned  win;
    logic         found;
    logic         vc_ok;
    logic [VC_W-1:0] free_vc;
    idx        = 0;
    win        = 0;
    found      = 1'b0;
    vc_ok      = 1'b0;
    free_vc    = '0;
    grant_d    = '0;
    grant_vc_d = '0;
    alloc      = '0;
    // A requester already holding a grant pulse is not re-arbitrated.
    elig_req   = req & ~grant_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rr_ptr_d[p] = rr_ptr_q[p];
      vc_ok   = 1'b0;
      free_vc = '0;
      // Ascending scan leaves the highest free index in free_vc.
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        if (avail_q[p*NUM_VCS+v]) begin
          vc_ok   = 1'b1;
          free_vc = VC_W'(v);
        end
      end
      found = 1'b0;
      win   = 0;
      for (int unsigned i = 0; i < NR; i++) begin
        idx = (int'(rr_ptr_q[p]) + i) % NR;
        if (!found && elig_req[idx] &&
            req_outport[idx*PORT_W +: PORT_W] == PORT_W'(p)) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && vc_ok) begin
        grant_d[win]                  = 1'b1;
        grant_vc_d[win*VC_W +: VC_W]  = free_vc;
        alloc[p*NUM_VCS+int'(free_vc)] = 1'b1;
        rr_ptr_d[p] = (win == NR - 1) ? '0 : RW'(win + 1);
      end
    end
    avail_d = (avail_q | vc_release) & ~alloc;
  end

  // Allocation state: availability, grant pulses and round-robin pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avail_q    <= '1;
      grant_q    <= '0;
      grant_vc_q <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) rr_ptr_q[p] <= '0;
    end else begin
      avail_q    <= avail_d;
      grant_q    <= grant_d;
      grant_vc_q <= grant_vc_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) rr_ptr_q[p] <= rr_ptr_d[p];
    end
  end

  assign grant           = grant_q;
  assign grant_vc        = grant_vc_q;
  assign vc_availability = avail_q;

`ifdef VCA_ERR_CHECK_EN
  logic err_q;

  // Sticky flag: a release hit a slot that was already free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (|(vc_release & avail_q));
    end
  end

  assign err_release = err_q;
`else
  // Release of an already-free slot is absorbed by the OR into availability.
`endif

endmodule

// File: tb/tb_vc_alloc_ctrl.sv
// Randomized self-checking bench for vc_alloc_ctrl with a behavioural allocation model.
// Define VCA_ERR_CHECK_EN to also check the err_release output.
module tb_vc_alloc_ctrl;

  localparam int NP = 5;
  localparam int NV = 4;
  localparam int NR = NP * NV;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0]   req;
  logic [NR*3-1:0] req_outport;
  logic [NR-1:0]   vc_release;
  wire  [NR-1:0]   grant;
  wire  [NR*2-1:0] grant_vc;
  wire  [NR-1:0]   vc_availability;
`ifdef VCA_ERR_CHECK_EN
  wire             err_release;
`endif

  vc_alloc_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_outport     (req_outport),
    .vc_release      (vc_release),
    .grant           (grant),
    .grant_vc        (grant_vc),
    .vc_availability (vc_availability)
`ifdef VCA_ERR_CHECK_EN
    ,
    .err_release     (err_release)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  bit [NR-1:0]   m_avail;
  bit [NR-1:0]   m_grant;
  bit            m_err;
  int            m_ptr [NP];
  bit [NR-1:0]   pend_drop;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int outport_of(input int r);
    logic [NR*3-1:0] v;
    v = req_outport;
    return int'(v[r*3 +: 3]);
  endfunction

  task automatic set_req(input int r, input int p);
    req[r] = 1'b1;
    req_outport[r*3 +: 3] = 3'(p);
  endtask

  task automatic model_reset();
    m_avail = '1;
    m_grant = '0;
    m_err   = 1'b0;
    for (int p = 0; p < NP; p++) m_ptr[p] = 0;
    pend_drop = '0;
  endtask

  // One clock: predict from the rules, clock, compare, commit, apply handshake drops.
  task automatic step();
    bit [NR-1:0]   n_grant;
    bit [NR*2-1:0] n_gvc;
    bit [NR*2-1:0] vmask;
    bit [NR-1:0]   n_avail;
    int            n_ptr [NP];
    int            best, bestd, d, fv;
    n_grant = '0;
    n_gvc   = '0;
    vmask   = '0;
    n_avail = m_avail | vc_release;
    for (int p = 0; p < NP; p++) begin
      n_ptr[p] = m_ptr[p];
      best  = -1;
      bestd = NR;
      for (int r = 0; r < NR; r++) begin
        if (req[r] && !m_grant[r] && outport_of(r) == p) begin
          d = (r + NR - m_ptr[p]) % NR;
          if (d < bestd) begin
            bestd = d;
            best  = r;
          end
        end
      end
      fv = -1;
      for (int v = NV - 1; v >= 0; v--) if (fv < 0 && m_avail[p*NV+v]) fv = v;
      if (best >= 0 && fv >= 0) begin
        n_grant[best]        = 1'b1;
        n_gvc[best*2 +: 2]   = 2'(fv);
        vmask[best*2 +: 2]   = 2'b11;
        n_avail[p*NV+fv]     = 1'b0;
        n_ptr[p]             = (best + 1) % NR;
      end
    end
`ifdef VCA_ERR_CHECK_EN
    m_err = m_err | (|(vc_release & m_avail));
`endif
    @(posedge clk);
    #1;
    check_eq("grant", 64'(grant), 64'(n_grant));
    check_eq("grant_vc", 64'(grant_vc & vmask), 64'(n_gvc));
    check_eq("vc_availability", 64'(vc_availability), 64'(n_avail));
`ifdef VCA_ERR_CHECK_EN
    check_eq("err_release", 64'(err_release), 64'(m_err));
`endif
    m_grant = n_grant;
    m_avail = n_avail;
    for (int p = 0; p < NP; p++) m_ptr[p] = n_ptr[p];
    vc_release = '0;
    req        = req & ~pend_drop;
    pend_drop  = m_grant;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    vc_release = '0;
    #1;
    model_reset();
    check_eq("reset_avail", 64'(vc_availability), 64'hFFFFF);
    check_eq("reset_grant", 64'(grant), 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int winner;
  int exp_order [4] = '{1, 5, 1, 5};
  int got;

  initial begin
    reset       = 1'b0;
    req         = '0;
    req_outport = '0;
    vc_release  = '0;
    model_reset();
    do_reset();

    // Single request to port 2 gets VC 3 (slot 11), no regrant while held.
    set_req(0, 2);
    step();
    check_eq("t2_grant0", 64'(grant[0]), 64'h1);
    check_eq("t2_vc", 64'(grant_vc[1:0]), 64'h3);
    check_eq("t2_av11", 64'(vc_availability[11]), 64'h0);
    step();
    check_eq("t2_noregrant", 64'(grant), 64'h0);
    vc_release[11] = 1'b1;
    step();

    // Three requesters to port 1 served on consecutive cycles with VCs 3,2,1.
    do_reset();
    set_req(0, 1);
    set_req(4, 1);
    set_req(8, 1);
    step();
    check_eq("t3_g0", 64'(grant), 64'h1);
    check_eq("t3_vc0", 64'(grant_vc[1:0]), 64'h3);
    step();
    check_eq("t3_g4", 64'(grant), 64'h10);
    check_eq("t3_vc4", 64'(grant_vc[9:8]), 64'h2);
    step();
    check_eq("t3_g8", 64'(grant), 64'h100);
    check_eq("t3_vc8", 64'(grant_vc[17:16]), 64'h1);
    step();

    // Port 3 exhausted; fifth requester waits until slot 13 is released.
    do_reset();
    for (int r = 0; r < 5; r++) set_req(r, 3);
    for (int k = 0; k < 4; k++) step();
    step();
    step();
    check_eq("t4_wait", 64'(grant), 64'h0);
    vc_release[13] = 1'b1;
    step();
    check_eq("t4_wait_rel", 64'(grant), 64'h0);
    step();
    check_eq("t4_grant4", 64'(grant[4]), 64'h1);
    check_eq("t4_vc4", 64'(grant_vc[9:8]), 64'h1);
    step();

    // Round-robin fairness between requesters 1 and 5 on port 0.
    do_reset();
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      if (!req[1] && !pend_drop[1]) set_req(1, 0);
      if (!req[5] && !pend_drop[5]) set_req(5, 0);
      step();
      if (grant[1] || grant[5]) begin
        winner = grant[1] ? 1 : 5;
        check_eq("t5_rr_order", 64'(winner), 64'(exp_order[got]));
        vc_release[0*NV + int'(grant_vc[winner*2 +: 2])] = 1'b1;
        got++;
      end
    end
    check_eq("t5_count", 64'(got), 64'h4);
    req = '0;
    step();
    step();

`ifdef VCA_ERR_CHECK_EN
    do_reset();
    vc_release[0] = 1'b1;
    step();
    check_eq("t6_err", 64'(err_release), 64'h1);
    step();
    check_eq("t6_sticky", 64'(err_release), 64'h1);
`endif

    // Random traffic with a mid-run reset.
    do_reset();
    for (int c = 0; c < 1800; c++) begin
      if (c == 900) begin
        reset = 1'b1;
        #1;
        check_eq("midrst_grant", 64'(grant), 64'h0);
        check_eq("midrst_avail", 64'(vc_availability), 64'hFFFFF);
        model_reset();
        req = '0;
        vc_release = '0;
        @(negedge clk);
        reset = 1'b0;
      end
      for (int r = 0; r < NR; r++) begin
        if (!req[r] && !pend_drop[r]) begin
          if ($urandom_range(0, 3) == 0) set_req(r, int'($urandom_range(0, 6)));
        end else if (req[r] && !pend_drop[r] && $urandom_range(0, 19) == 0) begin
          req[r] = 1'b0;
        end
      end
      for (int s = 0; s < NR; s++)
        if (!m_avail[s] && $urandom_range(0, 4) == 0) vc_release[s] = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
